// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - shared state encoding, halt codes and reset PC for core_seq
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_REQ,
        ST_FETCH_WAIT,
        ST_EXEC,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_WB,
        ST_HALT
    } state_e;

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_EBREAK  = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL = 2'd2;
    localparam logic [1:0] HALT_BUSERR  = 2'd3;

    localparam logic [31:0] PC_RST_DEFAULT = 32'h8000_0000;

    // True while a fetch or memory transaction is outstanding (watchdog window)
    function automatic logic in_bus_txn(state_e s);
        return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT) ||
               (s == ST_MEM_REQ)   || (s == ST_MEM_WAIT);
    endfunction

endpackage

// File: rtl/core_seq_if.sv
// rtl/core_seq_if.sv - IFU/LSU handshakes, decode inputs and status outputs of core_seq
interface core_seq_if #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RETIRE_CNT_W = 64
);
    logic                    ifu_req_valid_o;
    logic                    ifu_req_ready_i;
    logic [XLEN-1:0]         ifu_req_addr_o;
    logic                    ifu_rsp_valid_i;
    logic [31:0]             ifu_rsp_data_i;
    logic                    ifu_rsp_err_i;
    logic [XLEN-1:0]         pc_o;
    logic [31:0]             inst_o;
    logic                    is_load_i;
    logic                    is_store_i;
    logic                    is_ebreak_i;
    logic                    is_illegal_i;
    logic                    wen_reg_i;
    logic [XLEN-1:0]         npc_i;
    logic                    lsu_req_valid_o;
    logic                    lsu_req_ready_i;
    logic                    lsu_rsp_valid_i;
    logic                    lsu_rsp_err_i;
    logic                    reg_wen_o;
    logic                    retire_o;
    logic [RETIRE_CNT_W-1:0] retire_cnt_o;
    logic                    halt_o;
    logic [1:0]              halt_code_o;

    modport master (
        output ifu_req_valid_o, ifu_req_addr_o, pc_o, inst_o, lsu_req_valid_o,
               reg_wen_o, retire_o, retire_cnt_o, halt_o, halt_code_o,
        input  ifu_req_ready_i, ifu_rsp_valid_i, ifu_rsp_data_i, ifu_rsp_err_i,
               is_load_i, is_store_i, is_ebreak_i, is_illegal_i, wen_reg_i, npc_i,
               lsu_req_ready_i, lsu_rsp_valid_i, lsu_rsp_err_i
    );

    modport slave (
        input  ifu_req_valid_o, ifu_req_addr_o, pc_o, inst_o, lsu_req_valid_o,
               reg_wen_o, retire_o, retire_cnt_o, halt_o, halt_code_o,
        output ifu_req_ready_i, ifu_rsp_valid_i, ifu_rsp_data_i, ifu_rsp_err_i,
               is_load_i, is_store_i, is_ebreak_i, is_illegal_i, wen_reg_i, npc_i,
               lsu_req_ready_i, lsu_rsp_valid_i, lsu_rsp_err_i
    );
endinterface

// File: rtl/core_seq_wdog.sv
// rtl/core_seq_wdog.sv - transaction watchdog; expired_o in the LIMIT-th enabled cycle after clear
module core_seq_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/core_seq.sv
// rtl/core_seq.sv - multi-cycle core sequencer (fetch/exec/mem/writeback FSM)
// CORE_SEQ_TIMEOUT_EN adds a per-transaction watchdog that halts with a bus-error code.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] PC_RST       = XLEN'(PC_RST_DEFAULT),
    parameter int unsigned     TIMEOUT      = 255,
    parameter int unsigned     RETIRE_CNT_W = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    core_seq_if.master    bus
);
    state_e                  state_q, state_d;
    logic [XLEN-1:0]         pc_q, pc_d;
    logic [31:0]             inst_q, inst_d;
    logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]              code_q, code_d;
    logic                    wdog_expired;

`ifdef CORE_SEQ_TIMEOUT_EN
    logic wdog_clr;
    assign wdog_clr = ((state_d == ST_FETCH_REQ) && (state_q != ST_FETCH_REQ)) ||
                      ((state_d == ST_MEM_REQ)   && (state_q != ST_MEM_REQ));

    core_seq_wdog #(.LIMIT(TIMEOUT)) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (wdog_clr),
        .en_i      (in_bus_txn(state_q)),
        .expired_o (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH_REQ;
            ST_FETCH_REQ: begin
                if (bus.ifu_req_ready_i) begin
                    state_d = ST_FETCH_WAIT;
                end else if (wdog_expired) begin
                    state_d = ST_HALT;
                    code_d  = HALT_BUSERR;
                end
            end
            ST_FETCH_WAIT: begin
                // A response in the same cycle as expiry still wins
                if (bus.ifu_rsp_valid_i) begin
                    if (bus.ifu_rsp_err_i) begin
                        state_d = ST_HALT;
                        code_d  = HALT_BUSERR;
                    end else begin
                        inst_d  = bus.ifu_rsp_data_i;
                        state_d = ST_EXEC;
                    end
                end else if (wdog_expired) begin
                    state_d = ST_HALT;
                    code_d  = HALT_BUSERR;
                end
            end
            ST_EXEC: begin
                if (bus.is_illegal_i) begin
                    state_d = ST_HALT;
                    code_d  = HALT_ILLEGAL;
                end else if (bus.is_ebreak_i) begin
                    state_d = ST_HALT;
                    code_d  = HALT_EBREAK;
                    cnt_d   = cnt_q + RETIRE_CNT_W'(1);
                end else if (bus.is_load_i || bus.is_store_i) begin
                    state_d = ST_MEM_REQ;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM_REQ: begin
                if (bus.lsu_req_ready_i) begin
                    state_d = ST_MEM_WAIT;
                end else if (wdog_expired) begin
                    state_d = ST_HALT;
                    code_d  = HALT_BUSERR;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.lsu_rsp_valid_i) begin
                    state_d = bus.lsu_rsp_err_i ? ST_HALT : ST_WB;
                    code_d  = bus.lsu_rsp_err_i ? HALT_BUSERR : code_q;
                end else if (wdog_expired) begin
                    state_d = ST_HALT;
                    code_d  = HALT_BUSERR;
                end
            end
            ST_WB: begin
                pc_d    = bus.npc_i;
                cnt_d   = cnt_q + RETIRE_CNT_W'(1);
                state_d = ST_FETCH_REQ;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RST;
            inst_q  <= '0;
            cnt_q   <= '0;
            code_q  <= HALT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign bus.ifu_req_valid_o = (state_q == ST_FETCH_REQ);
    assign bus.ifu_req_addr_o  = pc_q;
    assign bus.lsu_req_valid_o = (state_q == ST_MEM_REQ);
    assign bus.pc_o            = pc_q;
    assign bus.inst_o          = inst_q;
    assign bus.reg_wen_o       = (state_q == ST_WB) && bus.wen_reg_i;
    // ebreak retires in EXEC itself since it never reaches WB
    assign bus.retire_o        = (state_q == ST_WB) ||
                                 ((state_q == ST_EXEC) && bus.is_ebreak_i && !bus.is_illegal_i);
    assign bus.retire_cnt_o    = cnt_q;
    assign bus.halt_o          = (state_q == ST_HALT);
    assign bus.halt_code_o     = code_q;
endmodule

// File: tb/tb_core_seq.sv
// tb/tb_core_seq.sv - directed table-driven bench for core_seq
module tb_core_seq;
    localparam logic [31:0] B   = 32'h8000_0000;
    localparam logic [31:0] I_A = 32'h0010_0093;
    localparam logic [31:0] I_L = 32'h0000_2103;
    localparam logic [31:0] I_S = 32'h0020_2023;
    localparam logic [31:0] I_E = 32'h0010_0073;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_seq_if #(.XLEN(32), .RETIRE_CNT_W(64)) bus ();

    core_seq #(
        .XLEN(32), .PC_RST(32'h8000_0000), .TIMEOUT(8), .RETIRE_CNT_W(64)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       nm;
        logic [10:0] in;
        logic [31:0] npc;
        logic [31:0] rdata;
        logic [4:0]  outs;
        logic [1:0]  code;
        logic [31:0] pc;
        logic [63:0] cnt;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passes = 0;

    function automatic vec_t mk(string nm, logic [10:0] in, logic [31:0] npc, logic [31:0] rd,
                                logic [4:0] outs, logic [1:0] code, logic [31:0] pc,
                                logic [63:0] cnt, logic [31:0] inst);
        vec_t v;
        v.nm = nm; v.in = in; v.npc = npc; v.rdata = rd; v.outs = outs;
        v.code = code; v.pc = pc; v.cnt = cnt; v.inst = inst;
        return v;
    endfunction

    // in = {ifu rdy,rv,err, lsu rdy,rv,err, load,store,ebreak,illegal,wen}
    task automatic drive(input logic [10:0] in, input logic [31:0] npc, input logic [31:0] rd);
        {bus.ifu_req_ready_i, bus.ifu_rsp_valid_i, bus.ifu_rsp_err_i,
         bus.lsu_req_ready_i, bus.lsu_rsp_valid_i, bus.lsu_rsp_err_i,
         bus.is_load_i, bus.is_store_i, bus.is_ebreak_i, bus.is_illegal_i,
         bus.wen_reg_i} = in;
        bus.npc_i          = npc;
        bus.ifu_rsp_data_i = rd;
    endtask

    // {ifu_v, lsu_v, wen, retire, halt, code, pc, addr, cnt, inst}
    function automatic logic [255:0] snap();
        return {bus.ifu_req_valid_o, bus.lsu_req_valid_o, bus.reg_wen_o, bus.retire_o,
                bus.halt_o, bus.halt_code_o, bus.pc_o, bus.ifu_req_addr_o,
                bus.retire_cnt_o, bus.inst_o};
    endfunction

    function automatic logic [255:0] expv(logic [4:0] outs, logic [1:0] code, logic [31:0] pc,
                                          logic [63:0] cnt, logic [31:0] inst);
        return {outs, code, pc, pc, cnt, inst};
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        drive(11'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int bad;
        drive(11'b110_110_00001, B + 32'h40, 32'hDEAD_BEEF);

        // ALU, then load with 3-cycle stall + 2-cycle latency, then store, then ebreak
        tbl.push_back(mk("c00_idle",     11'b000_000_00000, 0,      0,   5'b00000, 0, B,     0, 0));
        tbl.push_back(mk("c01_freq",     11'b100_000_00000, 0,      0,   5'b10000, 0, B,     0, 0));
        tbl.push_back(mk("c02_fwait",    11'b010_000_00000, 0,      I_A, 5'b00000, 0, B,     0, 0));
        tbl.push_back(mk("c03_exec",     11'b000_000_00001, B+4,    0,   5'b00000, 0, B,     0, I_A));
        tbl.push_back(mk("c04_wb",       11'b000_000_00001, B+4,    0,   5'b00110, 0, B,     0, I_A));
        tbl.push_back(mk("c05_freq",     11'b100_000_00000, 0,      0,   5'b10000, 0, B+4,   1, I_A));
        tbl.push_back(mk("c06_fwait",    11'b010_000_00000, 0,      I_L, 5'b00000, 0, B+4,   1, I_A));
        tbl.push_back(mk("c07_exec_ld",  11'b000_000_10001, B+8,    0,   5'b00000, 0, B+4,   1, I_L));
        tbl.push_back(mk("c08_mreq_st",  11'b000_000_10001, B+8,    0,   5'b01000, 0, B+4,   1, I_L));
        tbl.push_back(mk("c09_mreq_st",  11'b000_000_10001, B+8,    0,   5'b01000, 0, B+4,   1, I_L));
        tbl.push_back(mk("c10_mreq_st",  11'b000_000_10001, B+8,    0,   5'b01000, 0, B+4,   1, I_L));
        tbl.push_back(mk("c11_mreq_acc", 11'b000_100_10001, B+8,    0,   5'b01000, 0, B+4,   1, I_L));
        tbl.push_back(mk("c12_mwait",    11'b000_000_10001, B+8,    0,   5'b00000, 0, B+4,   1, I_L));
        tbl.push_back(mk("c13_mwait_rv", 11'b000_010_10001, B+8,    0,   5'b00000, 0, B+4,   1, I_L));
        tbl.push_back(mk("c14_wb_ld",    11'b000_000_10001, B+8,    0,   5'b00110, 0, B+4,   1, I_L));
        tbl.push_back(mk("c15_freq_ign", 11'b011_000_00000, 0,      0,   5'b10000, 0, B+8,   2, I_L));
        tbl.push_back(mk("c16_freq",     11'b100_000_00000, 0,      0,   5'b10000, 0, B+8,   2, I_L));
        tbl.push_back(mk("c17_fwait",    11'b010_000_00000, 0,      I_S, 5'b00000, 0, B+8,   2, I_L));
        tbl.push_back(mk("c18_exec_st",  11'b000_000_01000, B+12,   0,   5'b00000, 0, B+8,   2, I_S));
        tbl.push_back(mk("c19_mreq_rv",  11'b000_110_01000, B+12,   0,   5'b01000, 0, B+8,   2, I_S));
        tbl.push_back(mk("c20_mwait",    11'b000_010_01000, B+12,   0,   5'b00000, 0, B+8,   2, I_S));
        tbl.push_back(mk("c21_wb_st",    11'b000_000_01000, B+12,   0,   5'b00010, 0, B+8,   2, I_S));
        tbl.push_back(mk("c22_freq",     11'b100_000_00000, 0,      0,   5'b10000, 0, B+12,  3, I_S));
        tbl.push_back(mk("c23_fwait",    11'b010_000_00000, 0,      I_E, 5'b00000, 0, B+12,  3, I_S));
        tbl.push_back(mk("c24_exec_eb",  11'b000_000_00100, B+16,   0,   5'b00010, 0, B+12,  3, I_E));
        tbl.push_back(mk("c25_halt_eb",  11'b110_110_00100, B+16,   0,   5'b00001, 1, B+12,  4, I_E));

        // Reset values while held in reset with busy inputs
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_values", snap(), expv(5'b00000, 0, B, 0, 0));

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in, tbl[i].npc, tbl[i].rdata);
            @(negedge clk);
            check(tbl[i].nm, snap(), expv(tbl[i].outs, tbl[i].code, tbl[i].pc, tbl[i].cnt, tbl[i].inst));
            tick();
        end

        // Halt is absorbing for 100 cycles under random response noise
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            drive({1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0, 5'b00101},
                  B + 32'h80, $urandom);
            @(negedge clk);
            if (snap() !== expv(5'b00001, 1, B+12, 4, I_E)) bad++;
            tick();
        end
        check("halt_hold_100", 256'(bad), 256'(0));

        // Illegal in EXEC: no retire, code 2, pc unchanged, responses ignored afterwards
        reset_pulse();
        drive(11'b000_000_00000, 0, 0);           tick();
        drive(11'b100_000_00000, 0, 0);           tick();
        drive(11'b010_000_00000, 0, 32'hFFFF_FFFF); tick();
        drive(11'b000_000_00011, B+4, 0);
        @(negedge clk);
        check("ill_exec_no_strobe", 256'({bus.retire_o, bus.reg_wen_o, bus.halt_o}), 256'(0));
        tick();
        drive(11'b010_010_00011, B+4, 0);
        @(negedge clk);
        check("ill_halt", snap(), expv(5'b00001, 2, B, 0, 32'hFFFF_FFFF));
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            drive({1'b1, 1'(k), 1'b0, 1'b1, 1'(~k), 1'b0, 5'b00001}, B+4, 32'h1234_5678);
            @(negedge clk);
            if (snap() !== expv(5'b00001, 2, B, 0, 32'hFFFF_FFFF)) bad++;
        end
        check("ill_rsp_ignored", 256'(bad), 256'(0));

        // Retire one ALU op, then async reset in MEM_WAIT of a load
        tick();
        reset_pulse();
        drive(11'b000_000_00000, 0, 0);    tick();
        drive(11'b100_000_00000, 0, 0);    tick();
        drive(11'b010_000_00000, 0, I_A);  tick();
        drive(11'b000_000_00001, B+4, 0);  tick();
        drive(11'b000_000_00001, B+4, 0);  tick();
        drive(11'b100_000_00000, 0, 0);    tick();
        drive(11'b010_000_00000, 0, I_L);  tick();
        drive(11'b000_000_10001, B+8, 0);  tick();
        drive(11'b000_100_10001, B+8, 0);  tick();
        drive(11'b000_000_10001, B+8, 0);
        @(negedge clk);
        check("mwait_pre_reset", snap(), expv(5'b00000, 0, B+4, 1, I_L));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", snap(), expv(5'b00000, 0, B, 0, 0));
        drive(11'b010_010_00000, 0, 32'hBAD0_BAD0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("restart_fetch_pc_rst", snap(), expv(5'b10000, 0, B, 0, 0));
        tick();
        @(negedge clk);
        check("stale_rsp_ignored", snap(), expv(5'b10000, 0, B, 0, 0));

        // LSU error response halts with code 3, nothing retired
        drive(11'b100_000_00000, 0, 0);    tick();
        drive(11'b010_000_00000, 0, I_L);  tick();
        drive(11'b000_000_10001, B+4, 0);  tick();
        drive(11'b000_100_10001, B+4, 0);  tick();
        drive(11'b000_011_10001, B+4, 0);  tick();
        @(negedge clk);
        check("lsu_err_halt", snap(), expv(5'b00001, 3, B, 0, I_L));

        // IFU error response halts with code 3, instruction not latched
        tick();
        reset_pulse();
        drive(11'b000_000_00000, 0, 0);    tick();
        drive(11'b100_000_00000, 0, 0);    tick();
        drive(11'b011_000_00000, 0, I_A);  tick();
        drive(11'b000_000_00000, 0, 0);
        @(negedge clk);
        check("ifu_err_halt", snap(), expv(5'b00001, 3, B, 0, 0));

        // IFU never responds
        tick();
        reset_pulse();
        drive(11'b000_000_00000, 0, 0);    tick();
        drive(11'b100_000_00000, 0, 0);    tick();
        drive(11'b000_000_00000, 0, 0);
        repeat (6) tick();
        @(negedge clk);
        check("wait_cycle8_running", snap(), expv(5'b00000, 0, B, 0, 0));
        tick();
        @(negedge clk);
`ifdef CORE_SEQ_TIMEOUT_EN
        check("timeout_halt", snap(), expv(5'b00001, 3, B, 0, 0));
`else
        check("no_timeout_cycle9", snap(), expv(5'b00000, 0, B, 0, 0));
        repeat (20) tick();
        @(negedge clk);
        check("no_timeout_cycle29", snap(), expv(5'b00000, 0, B, 0, 0));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle core sequencer: the parametrised successor to the single-cycle core top. It replaces the implicit one-instruction-per-clock flow with an explicit FSM that drives IFU and LSU request/response handshakes, latches the PC and instruction, and gates register writeback and PC update. It retires instructions with a counter and halts on ebreak, illegal instruction, bus error or timeout. It sits between pcReg/ifu/idu/exu/lsu/regs and owns all stage sequencing.

## Interface
- XLEN, 32, datapath/PC width
- PC_RST, 32'h8000_0000, PC value after reset
- TIMEOUT, 255, max cycles spent in one memory transaction (REQ+WAIT) before halt
- RETIRE_CNT_W, 64, retire counter width
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-low
- ifu_req_valid_o  out  1  fetch request valid
- ifu_req_ready_i  in  1  IFU accepts request
- ifu_req_addr_o  out  XLEN  fetch address (= pc_o)
- ifu_rsp_valid_i  in  1  fetch data valid
- ifu_rsp_data_i  in  32  fetched instruction
- ifu_rsp_err_i  in  1  fetch bus error, qualified by rsp_valid
- pc_o  out  XLEN  current PC register
- inst_o  out  32  latched instruction to idu
- is_load_i / is_store_i / is_ebreak_i / is_illegal_i / wen_reg_i  in  1 each  idu decode of inst_o
- npc_i  in  XLEN  next PC from exu
- lsu_req_valid_o  out  1  memory request valid
- lsu_req_ready_i  in  1  LSU accepts request
- lsu_rsp_valid_i  in  1  load data / store ack
- lsu_rsp_err_i  in  1  LSU bus error, qualified by rsp_valid
- reg_wen_o  out  1  regfile write strobe
- retire_o  out  1  one-cycle retire pulse
- retire_cnt_o  out  RETIRE_CNT_W  retired instruction count
- halt_o  out  1  core halted
- halt_code_o  out  2  0 none, 1 ebreak, 2 illegal, 3 bus error/timeout

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- IDLE -> FETCH_REQ unconditionally.
- FETCH_REQ: ifu_req_valid_o=1. On valid&ready -> FETCH_WAIT.
- FETCH_WAIT: on rsp_valid, if err -> HALT(3). Otherwise latch inst_o -> EXEC.
- EXEC: decode is stable. Priority: illegal -> HALT(2), ebreak -> HALT(1) with retire, load|store -> MEM_REQ, else -> WB.
- MEM_REQ / MEM_WAIT: same handshake as fetch using lsu_*. A response without error -> WB. A response with error -> HALT(3).
- WB: reg_wen_o=wen_reg_i, pc_o<=npc_i, retire_o=1, retire_cnt_o+=1 (wraps modulo 2^RETIRE_CNT_W). Next state FETCH_REQ.
- HALT: absorbing; all req_valid=0, reg_wen_o=0. Only reset leaves it.
- Ebreak retire: retire_o pulses and the counter increments in the EXEC cycle. pc_o is not updated.
- Valid is held high with the address stable until accepted. An rsp_valid outside WAIT states is ignored.

## Timing
- Reset values: pc_o=PC_RST, inst_o=0, retire_cnt_o=0, halt_code_o=0. All strobes and valids are 0. State=IDLE.
- A response is never accepted in the same cycle as its request; the earliest response is the cycle after the handshake.
- Zero-wait memory (ready=1, rsp one cycle later):
  - ALU instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- reg_wen_o and retire_o are high for exactly one cycle, in WB.
- halt_o is asserted from the first cycle in HALT.
- Reset asserted mid-transaction: immediate return to IDLE. Outstanding responses after reset release are ignored until the next request.

## Configuration
- CORE_SEQ_TIMEOUT_EN defined: a watchdog counts cycles in each REQ+WAIT pair, cleared on state entry to REQ. Reaching TIMEOUT with no response -> HALT(3).
- Not defined: no watchdog; the core waits indefinitely. halt_code 3 then arises only from rsp_err.

## Structure
- Shared package core_seq_pkg:
  - state enum
  - halt code constants (HALT_NONE/EBREAK/ILLEGAL/BUSERR)
  - PC_RST default
- Sub-module core_seq_wdog: counter, clear, enable, expired output. Instantiated only under CORE_SEQ_TIMEOUT_EN.

## Test plan
- Reset release, IFU ready=1, rsp 1 cycle later, addi (wen=1), npc=PC_RST+4:
  - ifu_req_addr_o=0x8000_0000 in cycle 1.
  - reg_wen_o and retire_o pulse in cycle 4.
  - pc_o=0x8000_0004 and retire_cnt_o=1 afterwards.
- Load with lsu_req_ready_i low 3 cycles and rsp 2 cycles after accept:
  - lsu_req_valid_o is held for 4 cycles.
  - WB occurs exactly once; the instruction takes 10 cycles total.
- is_illegal_i=1 in EXEC -> halt_o=1, halt_code_o=2, no retire, pc_o unchanged; later rsp_valid pulses are ignored.
- ebreak -> halt_code_o=1, retire_cnt_o incremented by 1, halt_o stays high for 100 cycles.
- With CORE_SEQ_TIMEOUT_EN and TIMEOUT=8, IFU never responds -> HALT(3) after 8 cycles. Without the macro, the core remains in FETCH_WAIT.
- rst_i pulsed low while in MEM_WAIT -> outputs return to reset values asynchronously and the fetch restarts at PC_RST.
